pipe_stage: RTL and testbench

- Generic, parametrised pipeline stage register. Successor to the fixed-width stage registers between ID/EX/MEM/WB.
- Adds valid/ready handshake, back-pressure (stall), flush with bubble insertion (control zeroed, payload kept) and a saturating stall counter.
- One instance replaces each hand-built stage register; control and payload buses are concatenated by the instantiating stage.

---
 rtl/pipe_stage.sv | 119 +++++++++++
 tb/tb_pipe_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// pipe_stage: generic pipeline stage register with valid/ready handshake,
// back-pressure, flush with bubble insertion and a saturating stall counter.
//
// Configuration macro: PIPE_STAGE_SKID_EN
//   undefined - single entry, in_ready = ~out_valid | out_ready (combinational)
//   defined   - two-entry skid buffer (main + skid), in_ready = ~skid_valid
//               (registered, no combinational path from out_ready)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset (highest priority)
//   flush             kill all entries; control zeroed, payload kept
//   in_valid/in_ready upstream handshake; in_ctrl/in_data upstream beat
//   out_valid/out_ready downstream handshake; out_ctrl/out_data held beat
//                     (out_ctrl is all-zero whenever out_valid = 0)
//   stall_cnt/stall_clr saturating count of out_valid & ~out_ready edges, clear
module pipe_stage #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 139,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    logic inXfer;

`ifdef PIPE_STAGE_SKID_EN
    logic              skidValid;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] skidData;

    always_comb begin
        in_ready = ~skidValid;
        inXfer   = in_valid & in_ready;
    end

    // Main register advances whenever it is empty or draining; skid only
    // fills while main is stalled. A valid skid forces in_ready low, so skid
    // refill and input capture never collide in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
            skidData  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            skidValid <= 1'b0;
            skidCtrl  <= '0;
        end else if (~out_valid | out_ready) begin
            if (skidValid) begin
                out_valid <= 1'b1;
                out_ctrl  <= skidCtrl;
                out_data  <= skidData;
                skidValid <= 1'b0;
                skidCtrl  <= '0;
            end else if (inXfer) begin
                out_valid <= 1'b1;
                out_ctrl  <= in_ctrl;
                out_data  <= in_data;
            end else begin
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end
        end else if (inXfer) begin
            skidValid <= 1'b1;
            skidCtrl  <= in_ctrl;
            skidData  <= in_data;
        end
    end
`else
    always_comb begin
        in_ready = ~out_valid | out_ready;
        inXfer   = in_valid & in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (inXfer) begin
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
            out_data  <= in_data;
        end else if (out_valid & out_ready) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end
    end
`endif

    // Clear beats a coincident stall; flush does not touch the count.
    always_ff @(posedge clk) begin
        if (rst | stall_clr) begin
            stall_cnt <= '0;
        end else if (out_valid & ~out_ready & (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
module tb_pipe_stage;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 139;
    localparam int unsigned NW = 3;
    localparam int CNT_MAX = (1 << NW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [NW-1:0] stall_cnt;

    pipe_stage #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .stall_clr(stall_clr)
    );

    always #5 clk = ~clk;

    // Reference model: a FIFO of capacity CAP, a held payload and a counter.
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] heldM;
    int            cntM;
    int            nVec = 0;
    int            nErr = 0;

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = 1'($urandom);
        return r;
    endfunction

    function automatic logic expReady();
        if (CAP == 1) return (q.size() == 0) || out_ready;
        return q.size() < CAP;
    endfunction

    function automatic logic expValid();
        return q.size() > 0;
    endfunction

    function automatic logic [CW-1:0] expCtrl();
        return (q.size() > 0) ? q[0].c : '0;
    endfunction

    function automatic logic [DW-1:0] expData();
        return (q.size() > 0) ? q[0].d : heldM;
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        logic  rdy;
        beat_t b;
        rdy = expReady();
        if (rst) begin
            q.delete();
            cntM  = 0;
            heldM = '0;
        end else begin
            if (stall_clr) cntM = 0;
            else if (q.size() > 0 && !out_ready && cntM < CNT_MAX) cntM++;
            if (flush) q.delete();
            else begin
                if (out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && rdy) begin
                    b.c = in_ctrl;
                    b.d = in_data;
                    q.push_back(b);
                end
            end
            if (q.size() > 0) heldM = q[0].d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; in_valid = 0; out_ready = 0; stall_clr = 0;
        in_ctrl = '0; in_data = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        nVec++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        nVec++; if (out_ctrl !== '0) begin nErr++; $display("FAIL reset_ctrl: got %h want 0", out_ctrl); end
        nVec++; if (out_data !== '0) begin nErr++; $display("FAIL reset_data: got %h want 0", out_data); end
        nVec++; if (stall_cnt !== '0) begin nErr++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
        nVec++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_stream();
        logic [CW-1:0] e;
        logic [DW-1:0] d;
        idle();
        in_valid = 1; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            e = 8'(8'h11 + i);
            d = randData();
            in_ctrl = e; in_data = d;
            #1;
            nVec++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            nVec++; if (out_ctrl !== e) begin nErr++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, out_ctrl, e); end
            nVec++; if (out_data !== d) begin nErr++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, d); end
            nVec++; if (out_valid !== 1'b1) begin nErr++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
            nVec++; if (stall_cnt !== '0) begin nErr++; $display("FAIL stream_cnt[%0d]: got %0d want 0", i, stall_cnt); end
        end
        in_valid = 0;
        tick();
        nVec++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL stream_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] d;
        logic          wantRdy;
        idle();
        d = randData();
        in_valid = 1; out_ready = 1; in_ctrl = 8'h2A; in_data = d;
        tick();
        out_ready = 0; in_ctrl = 8'h2B; in_data = randData();
        for (int k = 0; k < 5; k++) begin
            #1;
            wantRdy = (CAP == 2 && k == 0) ? 1'b1 : 1'b0;
            nVec++; if (in_ready !== wantRdy) begin nErr++; $display("FAIL stall_ready[%0d]: got %b want %b", k, in_ready, wantRdy); end
            nVec++; if (out_ctrl !== 8'h2A) begin nErr++; $display("FAIL stall_ctrl[%0d]: got %h want 2a", k, out_ctrl); end
            nVec++; if (out_data !== d) begin nErr++; $display("FAIL stall_data[%0d]: got %h want %h", k, out_data, d); end
            tick();
        end
        nVec++; if (stall_cnt !== NW'(5)) begin nErr++; $display("FAIL stall_cnt: got %0d want 5", stall_cnt); end
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            nVec++; if (out_ctrl !== expCtrl()) begin nErr++; $display("FAIL stall_release[%0d]: got %h want %h", k, out_ctrl, expCtrl()); end
            nVec++; if (out_valid !== expValid()) begin nErr++; $display("FAIL stall_release_v[%0d]: got %b want %b", k, out_valid, expValid()); end
        end
        stall_clr = 1;
        tick();
        stall_clr = 0;
    endtask

    task automatic test_flush();
        logic [DW-1:0] d;
        idle();
        d = randData();
        in_valid = 1; out_ready = 1; in_ctrl = 8'h33; in_data = d;
        tick();
        flush = 1; in_ctrl = 8'hFF; in_data = DW'(16'h1234);
        tick();
        flush = 0; in_valid = 0;
        nVec++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        nVec++; if (out_ctrl !== 8'h00) begin nErr++; $display("FAIL flush_ctrl: got %h want 00", out_ctrl); end
        nVec++; if (out_data !== d) begin nErr++; $display("FAIL flush_data_held: got %h want %h", out_data, d); end
        for (int k = 0; k < 3; k++) begin
            tick();
            nVec++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL flush_leak[%0d]: got %b want 0", k, out_valid); end
        end
        // Flush while stalled with an offered beat.
        in_valid = 1; out_ready = 0; in_ctrl = 8'h3C; in_data = randData();
        tick();
        tick();
        flush = 1;
        tick();
        flush = 0; in_valid = 0;
        nVec++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL flush_stalled: got %b want 0", out_valid); end
        stall_clr = 1;
        tick();
    endtask

    task automatic test_saturation();
        idle();
        stall_clr = 1;
        tick();
        stall_clr = 0; in_valid = 1; out_ready = 1; in_ctrl = 8'h44; in_data = randData();
        tick();
        in_valid = 0; out_ready = 0;
        for (int k = 0; k < 10; k++) tick();
        nVec++; if (stall_cnt !== NW'(CNT_MAX)) begin nErr++; $display("FAIL sat_cnt: got %0d want %0d", stall_cnt, CNT_MAX); end
        stall_clr = 1;
        tick();
        nVec++; if (stall_cnt !== '0) begin nErr++; $display("FAIL sat_clr: got %0d want 0", stall_cnt); end
        stall_clr = 0;
        tick();
        nVec++; if (stall_cnt !== NW'(1)) begin nErr++; $display("FAIL sat_resume: got %0d want 1", stall_cnt); end
        out_ready = 1;
        tick();
    endtask

    task automatic test_mid_reset();
        idle();
        in_valid = 1; out_ready = 0;
        in_ctrl = 8'h55; in_data = randData(); tick();
        in_ctrl = 8'h66; in_data = randData(); tick();
        in_ctrl = 8'h77; in_data = randData(); tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        nVec++; if (out_valid !== 1'b0) begin nErr++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
        nVec++; if (out_ctrl !== '0) begin nErr++; $display("FAIL mrst_ctrl: got %h want 0", out_ctrl); end
        nVec++; if (out_data !== '0) begin nErr++; $display("FAIL mrst_data: got %h want 0", out_data); end
        nVec++; if (stall_cnt !== '0) begin nErr++; $display("FAIL mrst_cnt: got %0d want 0", stall_cnt); end
        nVec++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL mrst_ready: got %b want 1", in_ready); end
        in_valid = 0;
    endtask

    task automatic test_skid();
        logic [CW-1:0] beats [3];
        logic [CW-1:0] got[$];
        int            sent;
        int            cyc;
        beats[0] = 8'hA1; beats[1] = 8'hB2; beats[2] = 8'hC3;
        idle();
        sent = 0;
        out_ready = 0;
        for (int k = 0; k < 4; k++) begin
            in_valid = (sent < 3); in_ctrl = beats[sent % 3]; in_data = randData();
            #1;
            nVec++; if (in_ready !== expReady()) begin nErr++; $display("FAIL skid_ready[%0d]: got %b want %b", k, in_ready, expReady()); end
            if (in_valid && expReady()) sent++;
            tick();
        end
        nVec++; if (sent !== CAP) begin nErr++; $display("FAIL skid_accepted: got %0d want %0d", sent, CAP); end
        out_ready = 1;
        cyc = 0;
        while (got.size() < 3 && cyc < 20) begin
            in_valid = (sent < 3); in_ctrl = beats[sent % 3]; in_data = randData();
            #1;
            if (out_valid && out_ready) got.push_back(out_ctrl);
            if (in_valid && expReady()) sent++;
            tick();
            cyc++;
        end
        in_valid = 0;
        nVec++; if (got.size() !== 3) begin nErr++; $display("FAIL skid_count: got %0d want 3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            nVec++; if (got[i] !== beats[i]) begin nErr++; $display("FAIL skid_order[%0d]: got %h want %h", i, got[i], beats[i]); end
        end
        tick();
    endtask

    task automatic test_random();
        idle();
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 99) < 2);
            flush     = ($urandom_range(0, 99) < 5);
            stall_clr = ($urandom_range(0, 99) < 5);
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            in_ctrl   = CW'($urandom);
            in_data   = randData();
            #1;
            nVec++; if (in_ready !== expReady()) begin nErr++; $display("FAIL rnd_ready[%0d]: got %b want %b", k, in_ready, expReady()); end
            nVec++; if (out_valid !== expValid()) begin nErr++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, out_valid, expValid()); end
            nVec++; if (out_ctrl !== expCtrl()) begin nErr++; $display("FAIL rnd_ctrl[%0d]: got %h want %h", k, out_ctrl, expCtrl()); end
            nVec++; if (out_data !== expData()) begin nErr++; $display("FAIL rnd_data[%0d]: got %h want %h", k, out_data, expData()); end
            nVec++; if (stall_cnt !== NW'(cntM)) begin nErr++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", k, stall_cnt, cntM); end
            tick();
        end
        idle();
    endtask

    initial begin
        cntM  = 0;
        heldM = '0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_saturation();
        test_mid_reset();
        test_skid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
